// File: rtl/index_detect_sequencer.sv
// index_detect_sequencer
//   Phase 0 detection sequencer sitting behind the INDEX frequency counter
//   (300 MHz HDD clock domain). Runs NUM_TRIALS counter measurements, drops
//   low-confidence results, majority-votes floppy/HDD/unknown and protects
//   each trial with a watchdog.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   detect_start/abort     sequence control (start sampled only when idle)
//   detect_busy/done       sequence status, done is a one-cycle pulse
//   cnt_start/abort        one-cycle pulses to the frequency counter
//   cnt_timeout            constant TRIAL_TIMEOUT for the counter
//   cnt_done/period/class/conf  counter result, valid with cnt_done
//   final_class/conf/period     voted verdict
//   votes_*, trials_run    tally of the last sequence
//   watchdog_err, aborted  sticky status of the last sequence
module index_detect_sequencer #(
    parameter int unsigned NUM_TRIALS    = 3,
    parameter logic [7:0]  MIN_CONF      = 8'd128,
    parameter logic [15:0] GAP_CLKS      = 16'd3000,
    parameter logic [29:0] WATCHDOG_CLKS = 30'd600_000_000,
    parameter logic [26:0] TRIAL_TIMEOUT = 27'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        detect_start,
    input  logic        detect_abort,
    output logic        detect_busy,
    output logic        detect_done,
    output logic        cnt_start,
    output logic        cnt_abort,
    output logic [26:0] cnt_timeout,
    input  logic        cnt_done,
    input  logic [26:0] cnt_period,
    input  logic [1:0]  cnt_class,
    input  logic [7:0]  cnt_conf,
    output logic [1:0]  final_class,
    output logic [7:0]  final_conf,
    output logic [26:0] final_period,
    output logic [2:0]  votes_floppy,
    output logic [2:0]  votes_hdd,
    output logic [2:0]  votes_none,
    output logic [2:0]  trials_run,
    output logic        watchdog_err,
    output logic        aborted
);

    localparam int unsigned PERIOD_W = 27;
    localparam int unsigned CONF_W   = 8;
    localparam int unsigned WD_W     = 30;
    localparam int unsigned GAP_W    = 16;

    localparam logic [3:0]      MAJ_LIMIT   = 4'(NUM_TRIALS);
    localparam logic [2:0]      TRIALS_LAST = 3'(NUM_TRIALS);
    localparam logic [WD_W-1:0] WD_LAST     = WATCHDOG_CLKS - WD_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_CLKS - GAP_W'(1);

    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_FLOPPY = 2'd1;
    localparam logic [1:0] CLS_HDD    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_TALLY,
        S_GAP,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t               state;
    logic [WD_W-1:0]      wd_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [CONF_W-1:0]    floppy_min_conf;
    logic [CONF_W-1:0]    hdd_min_conf;
    logic [PERIOD_W-1:0]  floppy_period;
    logic [PERIOD_W-1:0]  hdd_period;

    logic                 vote_floppy_c;
    logic                 vote_hdd_c;
    logic                 floppy_major_c;
    logic                 hdd_major_c;
    logic                 abort_c;
    logic [WD_W-1:0]      wd_next_c;

    // Constant timeout for the counter, independent of reset.
    assign cnt_timeout = TRIAL_TIMEOUT;

    // Per-trial vote qualification; class 3 and low confidence fall to none.
    assign vote_floppy_c = (cnt_class == CLS_FLOPPY) && (cnt_conf >= MIN_CONF);
    assign vote_hdd_c    = (cnt_class == CLS_HDD) && (cnt_conf >= MIN_CONF);

    // Strict majority of the configured trial count, compared at 4 bits.
    assign floppy_major_c = {votes_floppy, 1'b0} > MAJ_LIMIT;
    assign hdd_major_c    = {votes_hdd, 1'b0} > MAJ_LIMIT;

    // Abort is honoured only while a sequence is actually running.
    assign abort_c = detect_abort &&
                     ((state == S_START) || (state == S_WAIT) ||
                      (state == S_TALLY) || (state == S_GAP));

    assign wd_next_c = wd_cnt + WD_W'(1);

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            wd_cnt          <= '0;
            gap_cnt         <= '0;
            floppy_min_conf <= '1;
            hdd_min_conf    <= '1;
            floppy_period   <= '0;
            hdd_period      <= '0;
            detect_busy     <= 1'b0;
            detect_done     <= 1'b0;
            cnt_start       <= 1'b0;
            cnt_abort       <= 1'b0;
            final_class     <= CLS_NONE;
            final_conf      <= '0;
            final_period    <= '0;
            votes_floppy    <= '0;
            votes_hdd       <= '0;
            votes_none      <= '0;
            trials_run      <= '0;
            watchdog_err    <= 1'b0;
            aborted         <= 1'b0;
        end else begin
            cnt_start   <= 1'b0;
            cnt_abort   <= 1'b0;
            detect_done <= 1'b0;

            if (abort_c) begin
                // Abort beats a coincident cnt_done; the partial tally is kept.
                cnt_abort    <= (state == S_WAIT);
                aborted      <= 1'b1;
                final_class  <= CLS_NONE;
                final_conf   <= '0;
                final_period <= '0;
                detect_busy  <= 1'b0;
                detect_done  <= 1'b1;
                state        <= S_DONE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (detect_start && !detect_abort) begin
                            votes_floppy    <= '0;
                            votes_hdd       <= '0;
                            votes_none      <= '0;
                            trials_run      <= '0;
                            final_class     <= CLS_NONE;
                            final_conf      <= '0;
                            final_period    <= '0;
                            watchdog_err    <= 1'b0;
                            aborted         <= 1'b0;
                            floppy_min_conf <= '1;
                            hdd_min_conf    <= '1;
                            floppy_period   <= '0;
                            hdd_period      <= '0;
                            detect_busy     <= 1'b1;
                            state           <= S_START;
                        end
                    end

                    S_START: begin
                        cnt_start <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (cnt_done) begin
                            if (vote_floppy_c) begin
                                votes_floppy  <= votes_floppy + 3'd1;
                                floppy_period <= cnt_period;
                                if (cnt_conf < floppy_min_conf) begin
                                    floppy_min_conf <= cnt_conf;
                                end
                            end else if (vote_hdd_c) begin
                                votes_hdd  <= votes_hdd + 3'd1;
                                hdd_period <= cnt_period;
                                if (cnt_conf < hdd_min_conf) begin
                                    hdd_min_conf <= cnt_conf;
                                end
                            end else begin
                                votes_none <= votes_none + 3'd1;
                            end
                            trials_run <= trials_run + 3'd1;
                            state      <= S_TALLY;
                        end else if (wd_next_c == WD_LAST) begin
                            // Hung counter: kill it and count the trial as none.
                            cnt_abort    <= 1'b1;
                            watchdog_err <= 1'b1;
                            votes_none   <= votes_none + 3'd1;
                            trials_run   <= trials_run + 3'd1;
                            wd_cnt       <= wd_next_c;
                            gap_cnt      <= '0;
                            state        <= S_GAP;
                        end else begin
                            wd_cnt <= wd_next_c;
                        end
                    end

                    S_TALLY: begin
                        if (floppy_major_c || hdd_major_c || (trials_run == TRIALS_LAST)) begin
                            state <= S_DECIDE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end

                    S_GAP: begin
                        // A timed-out final trial also passes through here.
                        if (gap_cnt == GAP_LAST) begin
                            state <= (trials_run == TRIALS_LAST) ? S_DECIDE : S_START;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end

                    S_DECIDE: begin
                        if (floppy_major_c) begin
                            final_class  <= CLS_FLOPPY;
                            final_conf   <= floppy_min_conf;
                            final_period <= floppy_period;
                        end else if (hdd_major_c) begin
                            final_class  <= CLS_HDD;
                            final_conf   <= hdd_min_conf;
                            final_period <= hdd_period;
                        end else begin
                            final_class  <= CLS_NONE;
                            final_conf   <= '0;
                            final_period <= '0;
                        end
                        detect_busy <= 1'b0;
                        detect_done <= 1'b1;
                        state       <= S_DONE;
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/index_detect_sequencer.md
Name: index_detect_sequencer

Overview:
- Phase 0 detection stage directly downstream of the INDEX frequency counter, in the 300 MHz HDD clock domain.
- Runs NUM_TRIALS back-to-back counter measurements and filters each result by confidence.
- Majority-votes the filtered results into one floppy/HDD/unknown verdict for the personality selector.
- Guards against a hung counter with a per-trial watchdog.

Parameters:
- NUM_TRIALS, 3, number of measurements per detection; legal range 1..7.
- MIN_CONF, 8'd128, minimum per-trial confidence for the trial to count as a class vote.
- GAP_CLKS, 16'd3000, idle cycles between trials (10 us); must be ≥ 8.
- WATCHDOG_CLKS, 30'd600_000_000, maximum cycles from cnt_start to cnt_done (2 s).
- TRIAL_TIMEOUT, 27'd0, value driven on cnt_timeout; 0 selects the counter's internal default.

Ports:
- clk  in  1  300 MHz clock
- reset  in  1  synchronous, active-high
- detect_start  in  1  start pulse; sampled only in IDLE
- detect_abort  in  1  abort request
- detect_busy  out  1  sequence in progress
- detect_done  out  1  one-cycle completion pulse
- cnt_start  out  1  one-cycle start pulse to the counter
- cnt_abort  out  1  one-cycle abort pulse to the counter
- cnt_timeout  out  27  constant TRIAL_TIMEOUT
- cnt_done  in  1  counter completion pulse; results valid in the same cycle
- cnt_period  in  27  counter measured period
- cnt_class  in  2  0 = none, 1 = floppy, 2 = HDD, 3 = treated as none
- cnt_conf  in  8  counter confidence
- final_class  out  2  voted class
- final_conf  out  8  minimum confidence among winning votes
- final_period  out  27  period of the last winning trial
- votes_floppy  out  3  floppy vote count
- votes_hdd  out  3  HDD vote count
- votes_none  out  3  none/low-confidence vote count
- trials_run  out  3  trials completed
- watchdog_err  out  1  at least one trial timed out (sticky until next start)
- aborted  out  1  last sequence was aborted

Behaviour:
- Reset: every output = 0; state = IDLE; internal counters cleared. Reset mid-operation behaves identically; no cnt_abort is issued.
- cnt_timeout = TRIAL_TIMEOUT at all times, including reset.
- IDLE
  - detect_busy = 0.
  - On detect_start=1 with detect_abort=0: clear votes, trials_run, final_*, watchdog_err, aborted; detect_busy = 1 the next cycle; go to START.
  - If detect_start and detect_abort arrive together, abort wins and nothing starts.
  - detect_start while not in IDLE is ignored.
- START: assert cnt_start for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT
  - Watchdog increments every cycle.
  - On cnt_done:
    - The trial votes for its class only if cnt_class ∈ {1,2} and cnt_conf ≥ MIN_CONF; otherwise votes_none increments.
    - Winning-class bookkeeping: the class's last period is stored, and its minimum confidence is updated.
    - trials_run increments; go to TALLY.
  - Watchdog reaching WATCHDOG_CLKS-1 with no cnt_done:
    - cnt_abort pulses for one cycle; watchdog_err = 1.
    - votes_none and trials_run increment; go to GAP.
    - Any cnt_done arriving during GAP is ignored.
- TALLY (1 cycle)
  - Early exit to DECIDE if votes_floppy*2 > NUM_TRIALS or votes_hdd*2 > NUM_TRIALS.
  - Else go to DECIDE if trials_run == NUM_TRIALS.
  - Otherwise go to GAP.
- GAP: count GAP_CLKS cycles, then go to START.
- DECIDE (1 cycle)
  - Winner = the class whose votes*2 > NUM_TRIALS; set final_class, final_conf, final_period from it.
  - No winner (split or mostly none): final_class = 0, final_conf = 0, final_period = 0.
  - Go to DONE.
- DONE: detect_done = 1 for one cycle; detect_busy = 0; go to IDLE. Results hold until the next accepted start.
- detect_abort in START/WAIT/TALLY/GAP:
  - Pulse cnt_abort only if in WAIT.
  - aborted = 1, final_* = 0; vote counters keep the partial tally; go to DONE.
  - Abort coincident with cnt_done: abort wins and the result is discarded.
- Arithmetic: vote counters are 3 bits wide and cannot overflow (NUM_TRIALS ≤ 7). Majority is compared as a 4-bit value, {votes,1'b0} > NUM_TRIALS.
- The minimum-confidence tracker initialises to 8'hFF per class at start.

Test Plan:
- NUM_TRIALS=3; counter model returns class 2, conf 255, period 5_000_000 twice -> early exit after 2 trials, trials_run=2, final_class=2, final_conf=255, final_period=5_000_000, one detect_done pulse.
- Trials return (1,255,60M), (2,200,6M), (1,160,55M) -> votes_floppy=2, votes_hdd=1, final_class=1, final_conf=160, final_period=55_000_000.
- Trials return class 2 conf 100 three times -> votes_none=3, final_class=0, final_conf=0, final_period=0.
- Counter never asserts cnt_done, WATCHDOG_CLKS=1000 -> cnt_abort pulse at cycle 999 after cnt_start, watchdog_err=1, 3 trials, final_class=0; a late cnt_done during GAP does not change votes.
- detect_abort asserted in the same cycle as the second cnt_done -> cnt_abort pulse, aborted=1, votes reflect the first trial only, final_class=0, detect_done one cycle later.
- reset asserted during GAP -> next cycle all outputs 0, no cnt_start; a subsequent detect_start runs a clean sequence.
